// File: rtl/rep_control_wb.sv
// Writeback-stage sequencer for REP/REPE/REPNE string instructions: owns the
// iteration count and issues registered count-load, repeat and terminate strobes.
module rep_control_wb #(
    parameter int CW     = 32,
    parameter int FW     = 32,
    parameter int ZF_BIT = 6
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          WB_V,
    input  logic          rep_start,
    input  logic          rep_iter_done,
    input  logic [1:0]    rep_mode,
    input  logic [CW-1:0] count_in,
    input  logic [FW-1:0] current_flags,
    input  logic          flush,
    output logic [CW-1:0] count_out,
    output logic          ld_count,
    output logic          repeat_eip,
    output logic          terminate,
    output logic          busy,
    output logic          proto_err,
    output logic          state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_REPE  = 2'b01;
    localparam logic [1:0] MODE_REPNE = 2'b10;

    state_t        state, state_n;
    logic [1:0]    mode_q, mode_n;
    logic [CW-1:0] count_n;
    logic [CW-1:0] count_dec;
    logic          ld_n, rep_n, term_n, err_n;
    logic          zf, stop;
    logic          unused_flags;

    assign zf           = current_flags[ZF_BIT];
    assign unused_flags = ^current_flags;
    assign count_dec    = count_out - {{(CW-1){1'b0}}, 1'b1};
    // Mode 11 falls into neither flag test, so it behaves as plain REP.
    assign stop = (count_dec == '0)
               || ((mode_q == MODE_REPE)  && !zf)
               || ((mode_q == MODE_REPNE) &&  zf);
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        count_n = count_out;
        ld_n    = 1'b0;
        rep_n   = 1'b0;
        term_n  = 1'b0;
        err_n   = proto_err;
        if (flush) begin
            state_n = IDLE;
        end else if (WB_V) begin
            case (state)
                IDLE: begin
                    if (rep_start) begin
                        if (count_in == '0) begin
                            // Zero count: skip the body entirely, no count writeback.
                            term_n  = 1'b1;
                            count_n = '0;
                        end else begin
                            mode_n  = rep_mode;
                            count_n = count_in;
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    if (rep_start) begin
                        err_n = 1'b1;
                    end
                    if (rep_iter_done) begin
                        count_n = count_dec;
                        ld_n    = 1'b1;
                        if (stop) begin
                            term_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            rep_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            mode_q     <= 2'b00;
            count_out  <= '0;
            ld_count   <= 1'b0;
            repeat_eip <= 1'b0;
            terminate  <= 1'b0;
            busy       <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            mode_q     <= mode_n;
            count_out  <= count_n;
            ld_count   <= ld_n;
            repeat_eip <= rep_n;
            terminate  <= term_n;
            busy       <= (state_n == RUN);
            proto_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_rep_control_wb.sv
// Randomised and directed bench for rep_control_wb: a rule-level model predicts
// every strobe into a queue that an independent monitor drains.
module tb_rep_control_wb;

    localparam int ZF_BIT = 6;
    localparam int EW     = 16 + 3 + 32;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        WB_V = 1'b0;
    logic        rep_start = 1'b0;
    logic        rep_iter_done = 1'b0;
    logic [1:0]  rep_mode = 2'b00;
    logic [31:0] count_in = '0;
    logic [31:0] current_flags = '0;
    logic        flush = 1'b0;
    logic [31:0] count_out;
    logic        ld_count, repeat_eip, terminate, busy, proto_err, state_dbg;

    logic        wb_v16 = 1'b0;
    logic [15:0] count_in16 = '0;
    logic [15:0] count_out16;
    logic        ld16, rep16, term16, busy16, err16, st16;

    logic [15:0] cyc = '0;
    int          checks = 0;
    int          failures = 0;

    // Reference model state: what the DUT should hold after the coming edge.
    logic        m_busy = 1'b0;
    logic [1:0]  m_mode = 2'b00;
    logic [31:0] m_count = '0;
    logic        m_err = 1'b0;
    logic [EW-1:0] exp_q[$];

    rep_control_wb #(.CW(32), .FW(32), .ZF_BIT(ZF_BIT)) dut (
        .CLK(CLK), .CLR(CLR), .WB_V(WB_V), .rep_start(rep_start),
        .rep_iter_done(rep_iter_done), .rep_mode(rep_mode), .count_in(count_in),
        .current_flags(current_flags), .flush(flush), .count_out(count_out),
        .ld_count(ld_count), .repeat_eip(repeat_eip), .terminate(terminate),
        .busy(busy), .proto_err(proto_err), .state_dbg(state_dbg)
    );

    rep_control_wb #(.CW(16), .FW(16), .ZF_BIT(ZF_BIT)) dut16 (
        .CLK(CLK), .CLR(CLR), .WB_V(wb_v16), .rep_start(rep_start),
        .rep_iter_done(rep_iter_done), .rep_mode(rep_mode), .count_in(count_in16),
        .current_flags(current_flags[15:0]), .flush(flush), .count_out(count_out16),
        .ld_count(ld16), .repeat_eip(rep16), .terminate(term16),
        .busy(busy16), .proto_err(err16), .state_dbg(st16)
    );

    // Clock and cycle stamp
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 16'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic ld, input logic rep, input logic term, input logic [31:0] cnt);
        exp_q.push_back({cyc + 16'd1, ld, rep, term, cnt});
    endtask

    // Driver: applies one WB cycle and advances the model by the instruction rules.
    task automatic step(input logic v, input logic st, input logic it, input logic [1:0] md,
                        input logic [31:0] cnt, input logic zf, input logic fl);
        logic done;
        @(negedge CLK);
        WB_V = v; rep_start = st; rep_iter_done = it; rep_mode = md;
        count_in = cnt; flush = fl;
        current_flags = $urandom();
        current_flags[ZF_BIT] = zf;
        if (fl) begin
            m_busy = 1'b0;
        end else if (v) begin
            if (!m_busy) begin
                if (st) begin
                    if (cnt == 0) begin
                        m_count = 0;
                        push_exp(1'b0, 1'b0, 1'b1, 32'd0);
                    end else begin
                        m_busy = 1'b1; m_mode = md; m_count = cnt;
                    end
                end
            end else begin
                if (st) m_err = 1'b1;
                if (it) begin
                    m_count = m_count - 1;
                    done = (m_count == 0) || (m_mode == 2'd1 && !zf) || (m_mode == 2'd2 && zf);
                    push_exp(1'b1, !done, done, m_count);
                    if (done) m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    // Monitor: per-cycle state comparison plus queue-driven strobe checking.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge CLK);
            #1;
            check("busy", busy, m_busy);
            check("state_dbg", state_dbg, m_busy);
            check("count_out", count_out, m_count);
            check("proto_err", proto_err, m_err);
            check("rep_term_exclusive", repeat_eip & terminate, 1'b0);
            if (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] == cyc) begin
                e = exp_q.pop_front();
                check("strobe", {cyc, ld_count, repeat_eip, terminate, count_out}, e);
            end else begin
                check("unexpected_strobe", {ld_count, repeat_eip, terminate}, 3'b000);
            end
        end
    end

    initial begin
        // Reset block
        CLR = 1'b0;
        repeat (3) @(negedge CLK);
        CLR = 1'b1;
        idle(2);

        // REP, count 3, ZF toggling has no effect
        step(1, 1, 0, 2'd0, 32'd3, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b1, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b1, 0);
        settle();
        check("rep3_terminate", {terminate, ld_count, count_out}, {1'b1, 1'b1, 32'd0});
        idle(1);

        // REPNE, 0x10, ZF set on third iteration
        step(1, 1, 0, 2'd2, 32'h10, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b1, 0);
        settle();
        check("repne_terminate", {terminate, count_out}, {1'b1, 32'h0D});
        idle(2);

        // REPE: exhaustion at 1, then ZF=0 exit at 4
        step(1, 1, 0, 2'd1, 32'd1, 1'b1, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b1, 0);
        idle(1);
        step(1, 1, 0, 2'd1, 32'd4, 1'b1, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b0, 0);
        settle();
        check("repe_zf0_terminate", {terminate, repeat_eip, count_out}, {1'b1, 1'b0, 32'd3});
        idle(1);

        // Zero-count skip, then protocol error during RUN
        step(1, 1, 0, 2'd0, 32'd0, 1'b0, 0);
        settle();
        check("zero_count_skip", {terminate, ld_count, busy}, 3'b100);
        idle(1);
        step(1, 1, 0, 2'd0, 32'd2, 1'b0, 0);
        step(1, 1, 0, 2'd0, 32'd7, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b0, 0);
        settle();
        check("proto_err_sticky", {proto_err, terminate, count_out}, {1'b1, 1'b1, 32'd0});
        idle(2);

        // Flush colliding with iter_done
        step(1, 1, 0, 2'd0, 32'd2, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b0, 1);
        settle();
        check("flush_iter", {busy, ld_count, repeat_eip, terminate, count_out}, {4'b0000, 32'd2});
        idle(2);

        // Asynchronous reset mid-RUN
        step(1, 1, 0, 2'd0, 32'd5, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b0, 0);
        step(1, 0, 1, 2'd0, 32'd0, 1'b0, 0);
        idle(1);
        @(posedge CLK);
        #3;
        CLR = 1'b0;
        m_busy = 1'b0; m_count = '0; m_err = 1'b0; m_mode = 2'd0;
        exp_q.delete();
        #1;
        check("async_reset", {busy, ld_count, repeat_eip, terminate, proto_err, count_out},
              {5'b00000, 32'd0});
        @(negedge CLK);
        CLR = 1'b1;
        idle(1);

        // 16-bit build wraps at 16 bits
        @(negedge CLK);
        WB_V = 1'b0; wb_v16 = 1'b1; rep_start = 1'b1; rep_iter_done = 1'b0;
        rep_mode = 2'd0; count_in16 = 16'hFFFF; flush = 1'b0;
        @(negedge CLK);
        rep_start = 1'b0; rep_iter_done = 1'b1;
        settle();
        check("cw16_iter", {count_out16, rep16, ld16, term16, busy16}, {16'hFFFE, 4'b1101});
        @(negedge CLK);
        wb_v16 = 1'b0; rep_iter_done = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 6)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
        end
        idle(3);
        settle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rep_control_wb.md
Name: rep_control_wb

Overview:
Writeback-stage sequencer for repeated string instructions (REP, REPE, REPNE). It owns the iteration count, decides after every completed iteration whether to repeat or terminate, and drives the count, EIP-select and redirect strobes. It sits beside the WB operand/flag logic and replaces single-mode REPNE termination with a parametrised, multi-mode, stateful controller.

Parameters:
CW, 32, width of the count register (ECX/CX image)
FW, 32, width of the flags vector input
ZF_BIT, 6, bit index of ZF within the flags vector

Ports:
CLK  in  1  clock; all state changes on the rising edge
CLR  in  1  reset; asynchronous, active-low
WB_V  in  1  WB stage valid; every other input is ignored when 0
rep_start  in  1  first uop of a repeated string instruction is in WB
rep_iter_done  in  1  last uop of one iteration is in WB
rep_mode  in  2  00 REP, 01 REPE, 10 REPNE, 11 reserved (treated as REP); sampled on start
count_in  in  CW  initial count; sampled on start
current_flags  in  FW  flags after this uop's update
flush  in  1  pipeline flush; aborts any sequence
count_out  out  CW  remaining count to write back
ld_count  out  1  pulse: write count_out to the count register
repeat_eip  out  1  pulse: reload the current instruction EIP (iterate again)
terminate  out  1  pulse: sequence finished; load the fall-through EIP
busy  out  1  sequence in progress
proto_err  out  1  sticky: rep_start seen while busy

Behaviour:
- Reset (CLR=0, asynchronous): state IDLE; count_out=0; ld_count, repeat_eip, terminate, busy=0; proto_err=0; mode register=00.
- All outputs are registered. Each pulse is high for exactly one cycle, in the cycle after the triggering WB_V-qualified input.
- States: IDLE, RUN.
- IDLE, WB_V&rep_start:
  - count_in==0: next cycle terminate=1, ld_count=0, count_out=0; stay IDLE (zero-count skip; no iteration executes).
  - count_in!=0: latch rep_mode, count_out<=count_in, go RUN, busy=1. No pulse.
- IDLE, rep_iter_done without start: ignored.
- RUN, WB_V&rep_iter_done:
  - next = count_out-1, modulo 2^CW. next is never below 0 because RUN implies a nonzero count.
  - count_out<=next; ld_count=1.
  - Stop when any of: next==0; mode REPE and ZF==0; mode REPNE and ZF==1. ZF=current_flags[ZF_BIT].
  - Stop: terminate=1, go IDLE, busy=0.
  - Otherwise: repeat_eip=1, stay RUN.
- repeat_eip and terminate are never high in the same cycle.
- RUN, WB_V&rep_start: proto_err<=1 (sticky until reset). The start is ignored and the state is unchanged. If rep_iter_done is asserted in the same cycle, it is still processed.
- rep_start and rep_iter_done together in IDLE: start has priority; iter_done is ignored.
- flush (independent of WB_V) has the highest priority in any state:
  - go IDLE, busy=0, no pulses next cycle;
  - count_out keeps its last value;
  - proto_err is unchanged.
- WB_V=0: state, count and pulses hold idle (pulses deassert).
- CW=16 mode: all arithmetic wraps at 16 bits. Upper flag bits beyond ZF_BIT are ignored.

Test Plan:
- Reset mid-RUN: REP, count 5, two iterations done, then CLR low asynchronously mid-cycle -> immediately busy=0, count_out=0, all pulses 0, proto_err=0.
- REP, count_in=3, three iter_done with ZF toggling:
  - 1st -> repeat_eip, count_out=2; 2nd -> repeat_eip, count_out=1; 3rd -> terminate, count_out=0, ld_count each time.
  - ZF has no effect in REP mode.
- REPNE, count_in=0x10, ZF=0,0, then 1 on the 3rd iteration -> repeat, repeat, then terminate with count_out=0x0D; busy drops the cycle after.
- REPE, count_in=1, ZF=1 -> terminate with count_out=0 (count exhaustion). Repeat with count 4 and ZF=0 on the 1st iteration -> terminate with count_out=3.
- count_in=0 start -> single terminate pulse, ld_count=0, busy stays 0. Then rep_start while RUN (count 2) -> proto_err=1 and remains 1; the sequence completes normally.
- flush in the same cycle as rep_iter_done in RUN (count 2) -> next cycle no pulses, IDLE, count_out=2. Also check the CW=16 build with count_in=16'hFFFF: one iteration gives count_out=16'hFFFE and repeat_eip.
